// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: operation request, HI/LO write and result bundle for the multiply/divide unit.
interface mul_div_unit_if #(parameter int WIDTH = 32);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cancel;
   logic             hi_we;
   logic [WIDTH-1:0] hi_wdata;
   logic             lo_we;
   logic [WIDTH-1:0] lo_wdata;
   logic             in_ready;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   modport master (output start, op, a, b, cancel, hi_we, hi_wdata, lo_we, lo_wdata,
                   input in_ready, done, hi, lo);
   modport slave  (input start, op, a, b, cancel, hi_we, hi_wdata, lo_we, lo_wdata,
                   output in_ready, done, hi, lo);
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative radix-2 multiply / restoring divide with HI/LO registers.
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input logic          clk,
   input logic          resetn,
   mul_div_unit_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
   state_t             state_q, state_d;
   logic               div_q, div_d, neg_q, neg_d, nega_q, nega_d, dz_q, dz_d, done_q, done_d;
   logic [WIDTH-1:0]   m_q, m_d, hi_q, hi_d, lo_q, lo_d;
   logic [2*WIDTH-1:0] p_q, p_d, prod;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               accept, sgn, div_ge;
   logic [WIDTH-1:0]   a_abs, b_abs, quo, rem;
   logic [WIDTH:0]     add_s, div_sh, div_df;
   assign accept = bus.start && !bus.cancel && state_q == IDLE;
   assign sgn    = !bus.op[0];
   assign a_abs  = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
   assign b_abs  = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         div_q   <= 1'b0;
         neg_q   <= 1'b0;
         nega_q  <= 1'b0;
         dz_q    <= 1'b0;
         done_q  <= 1'b0;
         m_q     <= '0;
         p_q     <= '0;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         neg_q   <= neg_d;
         nega_q  <= nega_d;
         dz_q    <= dz_d;
         done_q  <= done_d;
         m_q     <= m_d;
         p_q     <= p_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end
   always_comb begin
      state_d = bus.cancel ? IDLE :
                state_q == IDLE ? (bus.start ? CALC : IDLE) :
                state_q == CALC ? (cnt_q == CW'(WIDTH-1) ? FIX : CALC) : IDLE;
   end
   // Multiply keeps the multiplier in the low half of p; divide keeps the dividend/quotient there
   // and the partial remainder in the high half, so one accumulator serves both.
   always_comb begin
      add_s  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
      div_sh = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
      div_df = div_sh - {1'b0, m_q};
      div_ge = div_sh >= {1'b0, m_q};
      quo    = p_q[WIDTH-1:0];
      rem    = p_q[2*WIDTH-1:WIDTH];
      prod   = neg_q ? -p_q : p_q;
      div_d  = div_q;
      neg_d  = neg_q;
      nega_d = nega_q;
      dz_d   = dz_q;
      m_d    = m_q;
      p_d    = p_q;
      cnt_d  = cnt_q;
      hi_d   = hi_q;
      lo_d   = lo_q;
      done_d = 1'b0;
      if (accept) begin
         div_d  = bus.op[1];
         neg_d  = sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
         nega_d = sgn && bus.a[WIDTH-1];
         dz_d   = bus.op[1] && bus.b == '0;
         m_d    = bus.op[1] ? b_abs : a_abs;
         p_d    = {{WIDTH{1'b0}}, bus.op[1] ? a_abs : b_abs};
         cnt_d  = '0;
      end else if (state_q == IDLE) begin
         hi_d = bus.hi_we ? bus.hi_wdata : hi_q;
         lo_d = bus.lo_we ? bus.lo_wdata : lo_q;
      end else if (state_q == CALC && !bus.cancel) begin
         cnt_d = cnt_q + 1'b1;
         p_d   = div_q ? {div_ge ? div_df[WIDTH-1:0] : div_sh[WIDTH-1:0], quo[WIDTH-2:0], div_ge}
                       : {add_s, p_q[WIDTH-1:1]};
      end else if (state_q == FIX && !bus.cancel) begin
         done_d = 1'b1;
         hi_d   = div_q ? (nega_q ? -rem : rem) : prod[2*WIDTH-1:WIDTH];
         lo_d   = div_q ? (dz_q ? '1 : neg_q ? -quo : quo) : prod[WIDTH-1:0];
      end
   end
   assign bus.in_ready = state_q == IDLE;
   assign bus.done     = done_q;
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors with a result scoreboard checked on every done pulse.
module tb_mul_div_unit;
   localparam int W = 32;
   localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   asserts = 0;
   int   fails = 0;
   logic [63:0] exp_q[$];
   always #5 clk = ~clk;
   mul_div_unit_if #(.WIDTH(W)) bus();
   mul_div_unit #(.WIDTH(W)) dut (.clk(clk), .resetn(resetn), .bus(bus));
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      asserts++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask
   always @(negedge clk) begin : monitor
      logic [63:0] e;
      if (bus.done === 1'b1) begin
         if (exp_q.size() == 0) begin
            asserts++;
            fails++;
            $display("FAIL stray_done: got done=1 at %0t, required no pending result", $time);
         end else begin
            e = exp_q.pop_front();
            chk("result", {bus.hi, bus.lo}, e);
         end
      end
   end
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit push, input logic [63:0] e);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      if (push) exp_q.push_back(e);
   endtask
   task automatic wait_done(input string name);
      int n = 0;
      bit busy_ok = 1'b1;
      do begin
         @(negedge clk);
         bus.start = 1'b0;
         n++;
         if (!bus.done && bus.in_ready) busy_ok = 1'b0;
      end while (!bus.done && n < 100);
      chk({name, "_latency"}, n, 34);
      chk({name, "_busy"}, busy_ok, 1);
   endtask
   task automatic idle_no_done(input string name);
      int dn = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) dn++;
      end
      chk(name, dn, 0);
   endtask
   initial begin
      bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.cancel = 0;
      bus.hi_we = 0; bus.hi_wdata = 0; bus.lo_we = 0; bus.lo_wdata = 0;
      #3;
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_done", bus.done, 0);
      chk("rst_hilo", {bus.hi, bus.lo}, 64'h0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      issue(MULT, 32'hFFFFFFFD, 32'd5, 1, 64'hFFFFFFFF_FFFFFFF1);
      wait_done("mult");
      issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 64'hFFFFFFFE_00000001);
      wait_done("multu");
      issue(DIVU, 32'd100, 32'd7, 1, {32'd2, 32'd14});
      wait_done("divu_b2b");
      issue(MULT, 32'hFFFFFFFE, 32'hFFFFFFFD, 1, 64'h00000000_00000006);
      wait_done("mult_negneg");
      issue(DIV, 32'hFFFFFFF9, 32'd2, 1, 64'hFFFFFFFF_FFFFFFFD);
      wait_done("div_neg");
      issue(DIV, 32'h80000000, 32'hFFFFFFFF, 1, 64'h00000000_80000000);
      wait_done("div_ovf");
      issue(DIV, 32'hFFFFFFF0, 32'd0, 1, 64'hFFFFFFF0_FFFFFFFF);
      wait_done("div_dz");
      issue(DIVU, 32'h12345678, 32'd0, 1, 64'h12345678_FFFFFFFF);
      wait_done("divu_dz");
      @(negedge clk);
      issue(MULT, 32'd6, 32'd7, 0, 64'h0);
      @(negedge clk);
      bus.start = 1'b0;
      bus.hi_we = 1'b1;
      bus.hi_wdata = 32'hDEADBEEF;
      repeat (9) @(negedge clk);
      bus.hi_we = 1'b0;
      bus.cancel = 1'b1;
      @(negedge clk);
      bus.cancel = 1'b0;
      chk("cancel_ready", bus.in_ready, 1);
      chk("cancel_hilo", {bus.hi, bus.lo}, 64'h12345678_FFFFFFFF);
      idle_no_done("cancel_no_done");
      bus.hi_we = 1'b1; bus.hi_wdata = 32'hA5A5A5A5;
      bus.lo_we = 1'b1; bus.lo_wdata = 32'h5A5A5A5A;
      @(negedge clk);
      bus.hi_we = 1'b0; bus.lo_we = 1'b0;
      chk("mthi_mtlo", {bus.hi, bus.lo}, 64'hA5A5A5A5_5A5A5A5A);
      bus.lo_we = 1'b1; bus.lo_wdata = 32'h11111111;
      @(negedge clk);
      bus.lo_we = 1'b0;
      chk("mtlo_only", {bus.hi, bus.lo}, 64'hA5A5A5A5_11111111);
      issue(MULT, 32'd9, 32'd9, 0, 64'h0);
      repeat (5) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      #2 resetn = 1'b0;
      #1;
      chk("midrst_hilo", {bus.hi, bus.lo}, 64'h0);
      chk("midrst_done", bus.done, 0);
      chk("midrst_ready", bus.in_ready, 1);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      bus.start = 1'b1; bus.cancel = 1'b1; bus.op = DIVU; bus.a = 32'd50; bus.b = 32'd5;
      @(negedge clk);
      bus.start = 1'b0; bus.cancel = 1'b0;
      chk("start_cancel_ready", bus.in_ready, 1);
      idle_no_done("start_cancel_no_done");
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end
endmodule
